// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC row controller and its helpers.
package mac_pkg;

  localparam int DW_DEF      = 8;
  localparam int WW_DEF      = 8;
  localparam int CW_DEF      = 16;
  localparam int COLUMN_DEF  = 6;
  localparam int LW_DEF      = 8;
  localparam int MAC_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mac_vld_pipe.sv
// Valid delay line mirroring the mac_row input-to-output latency.
// o_any reports whether any valid is still travelling through the stages.
module mac_vld_pipe #(
  parameter int MAC_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  output logic o_vld,
  output logic o_any
);

  logic [MAC_LAT-1:0] r_pipe;

  genvar gi;
  generate
    for (gi = 0; gi < MAC_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_pipe[gi] <= 1'b0;
          else        r_pipe[gi] <= i_vld;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_pipe[gi] <= 1'b0;
          else        r_pipe[gi] <= r_pipe[gi-1];
        end
      end
    end
  endgenerate

  assign o_vld = r_pipe[MAC_LAT-1];
  assign o_any = |r_pipe;

endmodule

// File: rtl/mac_row_ctrl.sv
// Frame controller for one MAC row: loads weights, streams activations, drains results.
// Define MAC_ROW_CTRL_BIAS_EN to drive the captured per-frame bias onto ci.
module mac_row_ctrl
  import mac_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int WW      = WW_DEF,
  parameter int CW      = CW_DEF,
  parameter int COLUMN  = COLUMN_DEF,
  parameter int LW      = LW_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [COLUMN*WW-1:0]       w_data,
  input  logic [LW-1:0]              len,
  input  logic [CW-1:0]              bias,
  input  logic                       x_valid,
  input  logic [DW-1:0]              x_data,
  output logic                       x_ready,
  output logic                       busy,
  output logic                       done,
  output logic [DW-1:0]              xi,
  output logic [COLUMN*WW-1:0]       wi,
  output logic [COLUMN*CW-1:0]       ci,
  output logic [COLUMN-1:0]          w_en,
  input  logic [COLUMN*(CW+1)-1:0]   co,
  output logic                       y_valid,
  output logic [COLUMN*(CW+1)-1:0]   y_data
);

  state_t        r_state;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;
  logic          r_xi_vld;
  logic          w_pipe_vld;
  logic          w_pipe_any;
  logic          w_xfer;
  logic          w_last;

  assign w_xfer = x_valid && x_ready && (r_state == STREAM);
  // Compare against len-1 so the count never has to represent len itself past 2^LW-1.
  assign w_last = (r_cnt == (r_len - LW'(1)));

  mac_vld_pipe #(
    .MAC_LAT (MAC_LAT)
  ) u_vld_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (r_xi_vld),
    .o_vld (w_pipe_vld),
    .o_any (w_pipe_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_xi_vld <= 1'b0;
      xi       <= '0;
      wi       <= '0;
      w_en     <= '0;
      x_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      y_valid  <= 1'b0;
      y_data   <= '0;
    end else begin
      w_en     <= '0;
      done     <= 1'b0;
      r_xi_vld <= 1'b0;
      y_valid  <= w_pipe_vld;
      y_data   <= co;
      case (r_state)
        IDLE: begin
          if (start) begin
            wi      <= w_data;
            r_len   <= len;
            r_cnt   <= '0;
            w_en    <= '1;
            busy    <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (r_len == '0) begin
            r_state <= DRAIN;
          end else begin
            x_ready <= 1'b1;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_xfer) begin
            xi       <= x_data;
            r_xi_vld <= 1'b1;
            r_cnt    <= r_cnt + LW'(1);
            if (w_last) begin
              x_ready <= 1'b0;
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!r_xi_vld && !w_pipe_any) begin
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MAC_ROW_CTRL_BIAS_EN
  logic [CW-1:0] r_bias;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_bias <= '0;
    else if (r_state == IDLE && start)  r_bias <= bias;
  end

  assign ci = {COLUMN{r_bias}};
`else
  assign ci = '0;
`endif

endmodule

// File: doc/mac_row_ctrl.md
MAC_ROW_CTRL -- requirements
Module: mac_row_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DW, 8, activation width.
- WW, 8, weight width per column.
- CW, 16, partial-sum width in.
- COLUMN, 6, MAC columns.
- LW, 8, frame-length width.
- MAC_LAT, 1, mac_row input-to-co latency in cycles.

REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset first; single clock; reset asynchronous, active-low.
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- start, in, 1, frame start pulse.
- w_data, in, COLUMN*WW, weights captured at start.
- len, in, LW, activation count for the frame (0 is legal).
- bias, in, CW, per-frame bias captured at start.
- x_valid, in, 1, activation valid.
- x_data, in, DW, activation.
- x_ready, out, 1, controller accepts x_data.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle end-of-frame pulse.
- xi, out, DW, to mac_row.
- wi, out, COLUMN*WW, to mac_row.
- ci, out, COLUMN*CW, to mac_row.
- w_en, out, COLUMN, to mac_row.
- co, in, COLUMN*(CW+1), from mac_row.
- y_valid, out, 1, y_data valid.
- y_data, out, COLUMN*(CW+1), registered copy of co.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, STREAM, DRAIN and DONE.
REQ-004 IDLE: start=1 SHALL capture w_data, len and bias, and SHALL move to LOAD. start is ignored in every other state.
REQ-005 LOAD SHALL last exactly one cycle, with w_en all ones and wi equal to the captured weights. Next state is STREAM, or DRAIN if len==0.
REQ-006 w_en SHALL be 0 in every state except LOAD.
REQ-007 STREAM SHALL drive x_ready=1. A transfer occurs when x_valid && x_ready.
REQ-008 On a transfer, xi SHALL be loaded with x_data, xi_vld SHALL be 1, and the count SHALL increment. With no transfer, xi SHALL hold and xi_vld SHALL be 0 (bubble).
REQ-009 When the count reaches len, x_ready SHALL drop in the same cycle as the last transfer's register update, and the FSM SHALL move to DRAIN.
REQ-010 DRAIN SHALL wait until every in-flight xi_vld has emerged from the MAC_LAT-deep valid pipe, then move to DONE.
REQ-011 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 The valid pipe SHALL delay xi_vld by MAC_LAT cycles. y_valid SHALL be the pipe output registered once more, and y_data SHALL be co registered on the same edge.
REQ-014 Total latency SHALL be MAC_LAT+1 cycles from the xi update to y_valid.
REQ-015 Bubbles SHALL NOT generate y_valid.
REQ-016 ci SHALL replicate the captured bias to every column (see REQ-020 for the compiled-out case).
REQ-017 The count SHALL be LW bits and SHALL NOT wrap. len=2^LW-1 is legal, and the count stops at len.

Reset
REQ-018 rst_n low, at any time including mid-frame, SHALL force the FSM to IDLE and clear the counter and the valid pipe.
REQ-019 Reset SHALL zero all of: xi, wi, ci, w_en, x_ready, busy, done, y_valid and y_data. No y_valid from an aborted frame SHALL appear after reset release.

Configuration
REQ-020 Macro MAC_ROW_CTRL_BIAS_EN.
- Defined: ci carries the captured bias per REQ-016.
- Undefined: ci is constant 0, the bias port remains but is ignored, and no bias register is built.

Structure
REQ-021 Shared package mac_pkg SHALL hold the FSM state typedef (IDLE, LOAD, STREAM, DRAIN, DONE) and the default DW, WW, CW, COLUMN, LW and MAC_LAT constants.
REQ-022 The valid delay line SHALL be the sub-module mac_vld_pipe, parameterised by depth MAC_LAT and with async active-low reset.
REQ-023 mac_row is instantiated outside this block, alongside it.

Verification
REQ-024 Scenario: w_data=48'h060504030201, len=4, bias=0, x=1,2,3,4 with continuous x_valid, MAC_LAT=1.
- w_en=6'b111111 for exactly 1 cycle.
- Exactly 4 y_valid pulses.
- done is asserted 1 cycle after the last y_valid.
REQ-025 Scenario: len=3 with x_valid gapped 1-0-1-0-1.
- Exactly 3 y_valid pulses, none during the gaps.
- x_ready drops after the 3rd transfer.
REQ-026 Scenario: len=0.
- Sequence is LOAD, DRAIN, DONE.
- Zero y_valid pulses.
- done is asserted 3 cycles after start.
REQ-027 Scenario: with BIAS_EN defined, bias=16'h0002.
- ci equals the bias replicated to all 6 columns.
- With BIAS_EN undefined, ci stays 0.
REQ-028 Scenario: rst_n pulsed low mid-STREAM after 2 of 5 transfers.
- All outputs are 0 asynchronously.
- busy=0 and no stray y_valid after release.
- A new start completes a full frame normally.
REQ-029 Scenario: start pulsed during STREAM.
- The pulse is ignored: captured weights and len are unchanged, and the frame completes with the original count.
